// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared definitions for the RV32M divide unit.
//   - funct3 encodings for DIV/DIVU/REM/REMU
//   - divider FSM state enum
//   - special-case result constants
//   - small decode helpers used by the unit and its sign-fixup stage
package rv32m_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  // DIV and REM treat operands as two's complement.
  function automatic logic is_signed_op(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // REM and REMU return the remainder rather than the quotient.
  function automatic logic is_rem_op(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/div_sign_fixup.sv
// div_sign_fixup: combinational final stage of the divider.
// Turns the unsigned magnitude quotient/remainder into the architectural
// result, applying signs and the RISC-V divide-by-zero / overflow rules.
// Ports:
//   i_quo, i_rem   unsigned magnitude quotient and remainder
//   i_abs_a        |dividend| (used to rebuild the dividend on divide by zero)
//   i_sign_a       dividend was negative (signed ops only)
//   i_sign_b       divisor was negative (signed ops only)
//   i_funct3       operation select
//   i_div0         divisor was zero
//   i_ovf          signed overflow case INT_MIN / -1
//   o_result       final 32-bit result
module div_sign_fixup
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_abs_a,
  input  logic            i_sign_a,
  input  logic            i_sign_b,
  input  logic [2:0]      i_funct3,
  input  logic            i_div0,
  input  logic            i_ovf,
  output logic [XLEN-1:0] o_result
);

  logic [XLEN-1:0] w_quo_signed;
  logic [XLEN-1:0] w_rem_signed;
  logic [XLEN-1:0] w_dividend;
  logic [XLEN-1:0] w_quo_final;
  logic [XLEN-1:0] w_rem_final;

  // Signs are already gated to zero for unsigned ops, so no funct3 check here.
  assign w_quo_signed = (i_sign_a ^ i_sign_b) ? (-i_quo) : i_quo;
  assign w_rem_signed = i_sign_a ? (-i_rem) : i_rem;
  assign w_dividend   = i_sign_a ? (-i_abs_a) : i_abs_a;

  always_comb begin
    w_quo_final = w_quo_signed;
    w_rem_final = w_rem_signed;
    if (i_div0) begin
      w_quo_final = DIV_BY_ZERO_Q;
      w_rem_final = w_dividend;
    end else if (i_ovf) begin
      w_quo_final = INT_MIN;
      w_rem_final = '0;
    end
  end

  assign o_result = is_rem_op(i_funct3) ? w_rem_final : w_quo_final;

endmodule

// File: rtl/rv32m_div_unit.sv
// rv32m_div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// A request in IDLE runs 32 CALC iterations, then one FIX cycle; busy is
// high through CALC and FIX, and done pulses for one cycle afterwards with
// result held until the next done.
// Build option: define RV32M_DIV_FAST_PATH_EN to let divide-by-zero,
// signed overflow, |b| = 1 and |a| < |b| skip CALC entirely.
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   start      request, sampled only in IDLE (ignored together with flush)
//   funct3     100 DIV, 101 DIVU, 110 REM, 111 REMU
//   operand_a  dividend (rs1)
//   operand_b  divisor (rs2)
//   flush      abort the operation in progress
//   busy       operation in progress / stall request
//   done       one-cycle result-valid pulse
//   result     quotient or remainder
module rv32m_div_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e r_state;
  div_state_e w_state_next;

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_funct3;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [XLEN-1:0]  r_abs_a;
  logic [XLEN-1:0]  r_abs_b;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_result;
  logic             r_done;

  // ---------------- request decode (IDLE side) ----------------
  logic            w_in_signed;
  logic            w_in_sign_a;
  logic            w_in_sign_b;
  logic [XLEN-1:0] w_in_abs_a;
  logic [XLEN-1:0] w_in_abs_b;
  logic            w_fast;
  logic [XLEN-1:0] w_init_quo;
  logic [XLEN-1:0] w_init_rem;
  logic            w_accept;

  assign w_in_signed = is_signed_op(funct3);
  assign w_in_sign_a = w_in_signed & operand_a[XLEN-1];
  assign w_in_sign_b = w_in_signed & operand_b[XLEN-1];
  assign w_in_abs_a  = w_in_sign_a ? (-operand_a) : operand_a;
  assign w_in_abs_b  = w_in_sign_b ? (-operand_b) : operand_b;
  assign w_accept    = (r_state == DIV_IDLE) && start && !flush;

`ifdef RV32M_DIV_FAST_PATH_EN
  logic w_in_div0;
  logic w_in_ovf;
  logic w_in_b_one;
  logic w_in_a_lt_b;

  assign w_in_div0   = (operand_b == '0);
  assign w_in_ovf    = w_in_signed && (operand_a == INT_MIN) && (operand_b == '1);
  assign w_in_b_one  = (w_in_abs_b == XLEN'(1));
  assign w_in_a_lt_b = (w_in_abs_a < w_in_abs_b);
  assign w_fast      = w_in_div0 | w_in_ovf | w_in_b_one | w_in_a_lt_b;

  // Preload quo/rem with the answer FIX expects; div0/ovf are forced in FIX
  // regardless of what lands here.
  assign w_init_quo = (!w_in_b_one && w_in_a_lt_b) ? '0 : w_in_abs_a;
  assign w_init_rem = (!w_in_b_one && w_in_a_lt_b) ? w_in_abs_a : '0;
`else
  assign w_fast     = 1'b0;
  assign w_init_quo = w_in_abs_a;
  assign w_init_rem = '0;
`endif

  // ---------------- one restoring step ----------------
  // The shifted partial remainder needs XLEN+1 bits; the borrow out of the
  // subtraction doubles as the "rem >= |b|" compare.
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_abs_b};
  assign w_ge    = ~w_diff[XLEN];

  // ---------------- special cases and fixup ----------------
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_fix_result;

  assign w_div0 = (r_abs_b == '0);
  assign w_ovf  = is_signed_op(r_funct3) && r_sign_a && r_sign_b &&
                  (r_abs_a == INT_MIN) && (r_abs_b == XLEN'(1));

  div_sign_fixup #(.XLEN(XLEN)) u_fixup (
    .i_quo    (r_quo),
    .i_rem    (r_rem),
    .i_abs_a  (r_abs_a),
    .i_sign_a (r_sign_a),
    .i_sign_b (r_sign_b),
    .i_funct3 (r_funct3),
    .i_div0   (w_div0),
    .i_ovf    (w_ovf),
    .o_result (w_fix_result)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= DIV_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DIV_IDLE: begin
        if (start && !flush) w_state_next = w_fast ? DIV_FIX : DIV_CALC;
      end
      DIV_CALC: begin
        if (flush)                            w_state_next = DIV_IDLE;
        else if (r_cnt == CNT_W'(XLEN - 1))   w_state_next = DIV_FIX;
      end
      DIV_FIX:  w_state_next = DIV_IDLE;
      default:  w_state_next = DIV_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_abs_a  <= '0;
      r_abs_b  <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_cnt    <= '0;
            r_funct3 <= funct3;
            r_sign_a <= w_in_sign_a;
            r_sign_b <= w_in_sign_b;
            r_abs_a  <= w_in_abs_a;
            r_abs_b  <= w_in_abs_b;
            r_quo    <= w_init_quo;
            r_rem    <= w_init_rem;
          end
        end
        DIV_CALC: begin
          if (!flush) begin
            r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DIV_FIX: begin
          // A flush here drops the result entirely: no update, no pulse.
          if (!flush) begin
            r_result <= w_fix_result;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != DIV_IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_rv32m_div_unit.sv
module tb_rv32m_div_unit;
  import rv32m_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  rv32m_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 CLK = ~CLK;

`ifdef RV32M_DIV_FAST_PATH_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h required=no done (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, " result"}, result, e.res);
        chk({e.name, " done_cycle"}, 32'(cyc), 32'(e.cyc));
        chk({e.name, " busy_with_done"}, {31'd0, busy}, 32'd0);
      end
    end
  end

  // Drive start for exactly one cycle; s is the cycle number start was high.
  task automatic start_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                          input bit push, input logic [31:0] expv, input bit fast,
                          input string name, output int s);
    @(posedge CLK); #1;
    start     = 1'b1;
    funct3    = f;
    operand_a = av;
    operand_b = bv;
    s = cyc;
    if (push) sb.push_back('{expv, cyc + ((FAST_EN && fast) ? 2 : 34), name});
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge CLK);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d pending required=0 pending", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int s;
    RST = 1'b1; start = 1'b0; flush = 1'b0; funct3 = F3_DIV;
    operand_a = '0; operand_b = '0;
    repeat (2) @(posedge CLK);
    #2;
    chk("reset busy",   {31'd0, busy}, 32'd0);
    chk("reset done",   {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge CLK); RST = 1'b0;

    // DIV 100/7 with full busy profile
    start_op(F3_DIV, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, "DIV 100/7", s);
    for (int k = 1; k <= 34; k++) begin
      @(negedge CLK);
      if (k == 1 || k == 17 || k == 33 || k == 34)
        chk($sformatf("DIV 100/7 busy@%0d", k), {31'd0, busy}, (k <= 33) ? 32'd1 : 32'd0);
    end
    wait_idle();

    start_op(F3_REM, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, "REM -100/7", s);
    wait_idle();
    start_op(F3_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 1'b0, "DIV -100/7", s);
    wait_idle();
    start_op(F3_DIVU, 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, "DIVU x/0", s);
    wait_idle();
    start_op(F3_REMU, 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678, 1'b1, "REMU x/0", s);
    wait_idle();
    start_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1, "DIV ovf", s);
    wait_idle();
    start_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, "REM ovf", s);
    wait_idle();
    start_op(F3_DIV, 32'hFFFF_FFF9, 32'd1, 1'b1, 32'hFFFF_FFF9, 1'b1, "DIV -7/1", s);
    wait_idle();
    start_op(F3_DIVU, 32'd5, 32'd9, 1'b1, 32'd0, 1'b1, "DIVU 5/9", s);
    wait_idle();
    start_op(F3_REM, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9, 1'b1, "REM -7/0", s);
    wait_idle();

    // Flush in cycle 10: no done, result held
    start_op(F3_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0, 1'b0, "flushed", s);
    repeat (9) @(posedge CLK);
    #1 flush = 1'b1;
    @(posedge CLK); #1 flush = 1'b0;
    @(negedge CLK);
    chk("flush busy_low", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge CLK);
    chk("flush result_held", result, 32'hFFFF_FFF9);

    // Asynchronous reset mid-CALC
    start_op(F3_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0, 1'b0, "reset_abort", s);
    repeat (14) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst busy_now",   {31'd0, busy}, 32'd0);
    chk("rst result_now", result, 32'd0);
    @(negedge CLK); RST = 1'b0;
    repeat (40) @(posedge CLK);

    // DIVU 9/2 then REMU 9/2 started in the done cycle
    start_op(F3_DIVU, 32'd9, 32'd2, 1'b1, 32'd4, 1'b0, "DIVU 9/2", s);
    repeat (32) @(posedge CLK);
    start_op(F3_REMU, 32'd9, 32'd2, 1'b1, 32'd1, 1'b0, "REMU 9/2 b2b", s);
    repeat (4) @(posedge CLK);
    #1;
    start = 1'b1; funct3 = F3_DIVU; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge CLK); #1 start = 1'b0;
    wait_idle();
    repeat (40) @(posedge CLK);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32m_div_unit.md
Name: rv32m_div_unit

Overview:
- Iterative radix-2 restoring divider for the M-extension DIV/DIVU/REM/REMU instructions.
- Sits beside the ALU in the EX stage and is fed from the ID_EX register.
- While it is busy, it stalls IF/ID/EX and holds EX_MEM as a bubble.
- It hands one 32-bit result to EX_MEM on a one-cycle done pulse.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- funct3  input  3  operation: 100 = DIV, 101 = DIVU, 110 = REM, 111 = REMU.
- operand_a  input  XLEN  dividend (rs1).
- operand_b  input  XLEN  divisor (rs2).
- flush  input  1  abort the operation in progress (branch mispredict or reset of the pipeline).
- busy  output  1  operation in progress; pipeline stall request.
- done  output  1  one-cycle pulse; result is valid.
- result  output  XLEN  quotient or remainder.

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately and mid-operation.
  - State goes to IDLE, counter to 0.
  - busy = 0, done = 0, result = 0.
  - All internal registers are cleared.
- States:
  - IDLE: waiting for start.
  - CALC: 32 iterations, one per cycle.
  - FIX: sign correction and writing of result.
- IDLE:
  - On start = 1: latch funct3, the operand signs, |a| and |b|, then go to CALC with count = 0.
  - |x| is the two's complement absolute value for DIV/REM and the raw value for DIVU/REMU.
  - start is ignored when not in IDLE.
- CALC, each cycle:
  - rem = {rem[XLEN-2:0], quo[XLEN-1]}; quo <<= 1.
  - If rem >= |b| (unsigned compare, XLEN+1 bits): rem -= |b| and quo[0] = 1.
  - count increments; after the 32nd iteration, go to FIX.
- FIX (one cycle), then back to IDLE:
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - result is registered and done pulses for the following cycle.
- Latency: start high in cycle 0; busy high in cycles 1..33; done high in cycle 34 only.
  - result is valid from cycle 34 and held until the next done.
  - A new start may be accepted in cycle 34.
- Special cases (RISC-V semantics, mandatory in both builds):
  - Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU), remainder = operand_a.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - Both are forced in FIX and override the iterative result.
- flush: in CALC or FIX, go to IDLE next cycle with no done pulse; result is unchanged. In IDLE, no effect.
- flush together with start in IDLE: start is ignored.
- done is never asserted in the same cycle as busy.

Optional Feature:
- Macro: RV32M_DIV_FAST_PATH_EN.
- Defined: in IDLE, detect divide by zero, signed overflow, |b| = 1, and |a| < |b| (unsigned, after abs).
  - On a hit, skip CALC and go straight to FIX. busy is high in cycle 1; done is high in cycle 2.
  - |b| = 1 gives quotient = a with sign fix, remainder 0.
  - |a| < |b| gives quotient 0, remainder = a.
- Undefined: every operation takes the full 34-cycle latency. Results are identical in both builds.

Decomposition:
- Shared package rv32m_pkg:
  - funct3 constants: F3_DIV, F3_DIVU, F3_REM, F3_REMU.
  - State enum: DIV_IDLE, DIV_CALC, DIV_FIX.
  - Constants: DIV_BY_ZERO_Q = 32'hFFFFFFFF, INT_MIN = 32'h80000000.
- Natural sub-module: div_sign_fixup, combinational; takes quo, rem, the signs, funct3 and the special-case flags, and produces the final result.

Test Plan:
- DIV 100 / 7: start in cycle 0 → done in cycle 34, result = 14; busy high in cycles 1..33.
- REM -100 / 7 → result 0xFFFFFFFE (-2). DIV -100 / 7 → 0xFFFFFFF2 (-14).
- DIVU 0x12345678 / 0 → 0xFFFFFFFF. REMU of the same operands → 0x12345678. Latency is 34 without the macro and 2 with it.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- Abort: flush in cycle 10, then RST pulsed mid-CALC on a later operation.
  - No done pulse in either case.
  - RST zeroes busy and result immediately.
  - The next DIVU 9 / 2 returns 4 with normal latency.
- Back-to-back: start asserted in the cycle done pulses (REMU 9 / 2) → accepted; second done 34 cycles later with result 1. A start asserted while busy is ignored.
